// File: rtl/instr_prefetch_pkg.sv
// Shared CPU constants and types used by the instruction prefetch stage.
package instr_prefetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] PC_INCR  = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
module prefetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates every read,
  // so stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: ROM address generation, one in-flight read, {pc,instr} buffer.
// Optional macro PREFETCH_BYPASS_EN forwards an arriving ROM word straight to Decode when the buffer is empty.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = instr_prefetch_pkg::NOP_WORD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  fetch_entry_t     head_entry;
  fetch_entry_t     resp_entry;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;

  logic credit_ok;
  logic issue;
  logic resp_arrive;
  logic bypass_hit;

  assign fifo_empty = (fifo_count == '0);

  // The in-flight read already owns a slot, so a push can never find the buffer full.
  assign credit_ok   = (int'(fifo_count) + int'(inflight)) < DEPTH;
  assign issue       = enable && !redirect && credit_ok;
  assign resp_arrive = enable && !redirect && inflight;
  assign fifo_flush  = enable && redirect;
  assign fifo_pop    = enable && !redirect && !stall && !fifo_empty;
  assign resp_entry  = '{pc: inflight_pc, instr: rom_data};

`ifdef PREFETCH_BYPASS_EN
  assign bypass_hit = enable && inflight && fifo_empty;
  // A forwarded word that Decode accepts directly never enters the buffer.
  assign fifo_push  = resp_arrive && !(bypass_hit && !stall);
`else
  assign bypass_hit = 1'b0;
  assign fifo_push  = resp_arrive;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (enable) begin
      if (redirect) begin
        fetch_pc <= word_align(redirect_pc);
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_pc <= fetch_pc;
          fetch_pc    <= fetch_pc + PC_INCR;
        end
      end
    end
  end

  assign rom_address = fetch_pc;

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .wr_data (resp_entry),
    .pop     (fifo_pop),
    .rd_data (head_entry),
    .count   (fifo_count)
  );

  // NOTE: every output gets a default first so this block never infers a latch.
  always_comb begin
    valid = 1'b0;
    instr = NOP_WORD;
    pc    = RESET_PC;
    if (!fifo_empty) begin
      valid = 1'b1;
      instr = head_entry.instr;
      pc    = head_entry.pc;
    end else if (bypass_hit && !redirect) begin
      valid = 1'b1;
      instr = rom_data;
      pc    = inflight_pc;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Scoreboard bench for instr_prefetch: expected fetch stream kept as a PC-ordered queue.
module tb_instr_prefetch;
  import instr_prefetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_BYPASS_EN
  localparam int FETCH_LAT = 1;
  localparam int REDIR_LAT = 2;
`else
  localparam int FETCH_LAT = 2;
  localparam int REDIR_LAT = 3;
`endif

  logic        clock;
  logic        reset;
  logic        enable;
  logic [31:0] rom_address;
  logic [31:0] rom_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;

  instr_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .NOP_WORD (NOP_WORD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr       (instr),
    .pc          (pc),
    .valid       (valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_next_pc;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  bit          mon_on   = 1'b0;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  // Synchronous ROM; holds its word while the pipeline is frozen.
  initial rom_data = 32'h0;
  always @(posedge clock) begin
    if (enable) rom_data <= rom_word(rom_address);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 2 * DEPTH + 4) begin
      exp_q.push_back('{pc: model_next_pc, instr: rom_word(model_next_pc)});
      model_next_pc += 32'd4;
    end
  endtask

  task automatic restart_model(input logic [31:0] start);
    exp_q.delete();
    model_next_pc = start & ~32'h3;
    refill();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    refill();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    enable      = 1'b1;
    redirect    = 1'b1;
    redirect_pc = target;
    restart_model(target);
    tick();
    redirect = 1'b0;
  endtask

  // Counts falling edges after the most recent rising edge until valid is seen.
  task automatic wait_valid(output int n, input int limit);
    n = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clock);
      if (valid) begin
        n = i;
        break;
      end
    end
  endtask

  // Monitor: every accepted instruction must be the next entry of the expected stream.
  always @(negedge clock) begin
    if (mon_on && reset) begin
      if (!valid) begin
        check("nop_when_invalid", instr, NOP_WORD);
      end else if (!stall && enable && !redirect) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got pc %h expected no output", pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_pc", pc, e.pc);
          check("out_instr", instr, e.instr);
          n_pops++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_addr;

    reset       = 1'b0;
    enable      = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;

    // Reset state
    #1;
    check("rst_rom_address", rom_address, RESET_PC);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_instr", instr, NOP_WORD);
    check("rst_pc", pc, RESET_PC);
    repeat (2) @(posedge clock);

    // Release: the next rising edge is the first issue edge
    #1;
    reset = 1'b1;
    restart_model(RESET_PC);
    mon_on = 1'b1;
    @(posedge clock);
    #1;
    wait_valid(n, 8);
    check("first_fetch_latency", n, FETCH_LAT);
    check("first_pc", pc, RESET_PC);
    check("first_instr", instr, 32'h1000_0000);

    // Streaming with stall=0 must present an instruction every cycle
    for (int i = 0; i < 8; i++) begin
      tick();
      @(negedge clock);
      check("stream_no_gap", {31'b0, valid}, 32'd1);
    end

    // Stall held: output frozen, buffer fills, address stops at next unissued PC
    tick();
    stall = 1'b1;
    @(negedge clock);
    hold_pc    = pc;
    hold_instr = instr;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clock);
      check("stall_pc_stable", pc, hold_pc);
      check("stall_instr_stable", instr, hold_instr);
    end
    check("stall_full_rom_address", rom_address, hold_pc + 32'(4 * DEPTH));
    tick();
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("stall_release_no_gap", {31'b0, valid}, 32'd1);
      tick();
    end

    // Redirect while the buffer holds words and a read is in flight
    stall = 1'b1;
    tick();
    tick();
    stall = 1'b0;
    do_redirect(32'h0000_0040);
    wait_valid(n, 8);
    check("redirect_latency", n, REDIR_LAT);
    check("redirect_pc_out", pc, 32'h0000_0040);

    // Redirect concurrent with a pop: popped word is not replayed
    repeat (5) tick();
    do_redirect(32'h0000_0203);
    wait_valid(n, 8);
    check("redirect_pop_latency", n, REDIR_LAT);
    check("redirect_pop_pc_out", pc, 32'h0000_0200);

    // enable low for three edges: everything holds, stream resumes in order
    repeat (5) tick();
    enable = 1'b0;
    @(negedge clock);
    hold_pc   = pc;
    hold_addr = rom_address;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clock);
      check("freeze_pc", pc, hold_pc);
      check("freeze_rom_address", rom_address, hold_addr);
    end
    tick();
    enable = 1'b1;
    repeat (6) tick();

    // Fetch address wraps past the top of the 32-bit space
    do_redirect(32'hFFFF_FFF8);
    repeat (8) tick();
    @(negedge clock);
    check("wrap_rom_address_low", {31'b0, rom_address < 32'h100}, 32'd1);

    // Asynchronous reset mid-stream takes effect before the next edge
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, valid}, 32'd0);
    check("async_rst_rom_address", rom_address, RESET_PC);
    check("async_rst_instr", instr, NOP_WORD);
    @(posedge clock);
    #1;
    reset = 1'b1;
    restart_model(RESET_PC);
    @(posedge clock);
    #1;
    wait_valid(n, 8);
    check("rst_again_latency", n, FETCH_LAT);
    check("rst_again_pc", pc, RESET_PC);

    // Randomized stall / enable / redirect traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        stall = ($urandom_range(0, 2) == 0);
        do_redirect(32'($urandom_range(0, 32'h3FF)));
      end else begin
        enable = ($urandom_range(0, 9) != 0);
        stall  = ($urandom_range(0, 2) == 0);
        tick();
      end
    end
    enable = 1'b1;
    stall  = 1'b0;
    repeat (20) tick();
    check("enough_pops", {31'b0, n_pops > 300}, 32'd1);

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Instruction prefetch stage between the synchronous instruction ROM and the Decode stage of the five-stage pipeline. It drives the ROM address and tracks one in-flight read. Returned words are buffered with their PCs in a small FIFO and presented to Decode with a valid/stall handshake. A branch/jump redirect from Execute flushes the buffer and discards the in-flight read.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_WORD, 32'h0000_0013: instruction presented while invalid (addi x0,x0,0).
- clock  in  1  single clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global run enable; when low, all state holds and no ROM read is issued.
- rom_address  out  32  byte address to the ROM; registered.
- rom_data  in  32  ROM word; valid in the cycle after the edge that sampled rom_address.
- redirect  in  1  flush request from Execute (taken branch/jump).
- redirect_pc  in  32  new fetch address; sampled when redirect=1.
- stall  in  1  Decode cannot accept this cycle.
- instr  out  32  head instruction, or NOP_WORD when valid=0.
- pc  out  32  PC of instr.
- valid  out  1  instr/pc hold a real fetched instruction.

## Operation
- State: fetch_pc, which drives rom_address; inflight flag and inflight_pc; FIFO of {pc, instr} with rd_ptr, wr_ptr and a count in 0..DEPTH.
- Issue: when enable=1 and count + inflight < DEPTH, the block issues a read. On that edge inflight is set, inflight_pc is loaded with fetch_pc, and fetch_pc increments by 4 (32-bit wrap).
- Response: when inflight=1, {inflight_pc, rom_data} is pushed into the FIFO on the next edge. Inflight clears unless a new read issues on the same edge.
- Pop: valid=1 and stall=0 pops the head on the edge. Push and pop in the same cycle leave count unchanged.
- The issue credit counts the in-flight read, so the FIFO never overflows and no push is dropped.
- Redirect has priority over every other event. On that edge:
  - count is cleared to 0 and rd_ptr=wr_ptr;
  - the in-flight response is discarded;
  - any concurrent pop is ignored;
  - fetch_pc takes redirect_pc;
  - no issue occurs, so the first read from the new PC issues on the following edge.
- redirect_pc[1:0] is forced to 0.
- valid=0 whenever count=0, except in the bypass case described under Configuration.

## Timing
- Reset values: rom_address=RESET_PC, valid=0, instr=NOP_WORD, pc=RESET_PC, count=0, inflight=0. Pointers are 0.
- Steady state with stall=0 sustains one instruction per cycle.
- Fetch latency from the issue edge to instr visible at the output:
  - without bypass: 2 cycles;
  - with bypass into an empty FIFO: 1 cycle.
- Redirect penalty: the redirect-target instruction appears at the output 3 cycles after the redirect edge without bypass, and 2 cycles with bypass.
- Stall held high: the FIFO fills to DEPTH and issuing stops. instr and pc stay stable, and rom_address holds the next unissued PC.
- enable=0 freezes all state, including the inflight response. The ROM must hold rom_data, so the response is captured once enable returns.
- Reset asserted mid-operation clears all state immediately. It does not wait for the clock.
- wr_ptr and rd_ptr wrap modulo DEPTH. count distinguishes the full state from the empty state.

## Configuration
- PREFETCH_BYPASS_EN defined: when count=0 and a response is arriving, instr, pc and valid come combinationally from rom_data and inflight_pc. Redirect=1 in that cycle forces valid=0.
  - If stall=0, the FIFO write is suppressed because the instruction is consumed directly.
  - If stall=1, the instruction is written to the FIFO as normal.
- Not defined: outputs come only from the FIFO head, with no rom_data-to-instr combinational path.

## Structure
- Shared cpu package holds:
  - NOP_WORD (32'h0000_0013);
  - XLEN=32;
  - the PC increment constant 4.
- One sub-module, prefetch_fifo: synchronous FIFO with parameterized DEPTH and width 64 ({pc, instr}), flush input, count output.
- instr_prefetch holds the fetch_pc and inflight logic and the bypass mux.

## Test plan
- Reset release, ROM holds word i = 32'h1000_0000+i, stall=0, no bypass:
  - valid rises 2 cycles after the first issue edge;
  - then 1 instruction per cycle: pc 0,4,8,… with instr 1000_0000,1000_0001,…
- Stall held 10 cycles after the first valid:
  - count reaches 4 and rom_address stops advancing;
  - instr/pc stay stable;
  - on release, 4 consecutive pops, then streaming resumes with no gaps and no duplicated or skipped PCs.
- Redirect to 0x40 while the FIFO is full and a read is in flight:
  - next cycle valid=0;
  - first valid output is pc=0x40 three cycles after the redirect edge;
  - no stale word appears.
- Redirect and pop in the same cycle: only the redirect takes effect; the popped entry is not replayed; the next output is pc=redirect_pc.
- enable=0 for 3 cycles mid-stream: the output sequence is identical to the enable=1 run, only delayed by 3 cycles.
- With PREFETCH_BYPASS_EN:
  - first valid 1 cycle after the issue edge;
  - after a redirect to 0x80, pc=0x80 is visible 2 cycles after the redirect edge.
